// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the four-way output arbiter.
// Combinational helpers only; no state lives in this package.
package rr_arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] req_idx_t;

  typedef enum logic {
    ARB_FREE,
    ARB_LOCK
  } arb_state_t;

  typedef struct packed {
    logic     found;
    req_idx_t idx;
  } pick_t;

  // Walk from ptr+3 down to ptr so the lowest rotation offset ends up winning.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] valid, input req_idx_t ptr);
    pick_t    r;
    req_idx_t c;
    r = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      c = ptr + req_idx_t'(k);
      if (valid[c]) begin
        r.found = 1'b1;
        r.idx   = c;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Requester and consumer channel bundle for rr_mux4_arbiter.
// The master side drives requests and consumer ready; the slave side is the arbiter.
interface rr_mux4_arbiter_if #(
  parameter int W = 4
) ();
  import rr_arb_pkg::*;

  logic [N_REQ-1:0]   in_valid;
  logic [N_REQ*W-1:0] in_data;
  logic [N_REQ-1:0]   in_ready;
  logic               out_valid;
  logic [W-1:0]       out_data;
  req_idx_t           out_src;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/rr_mux4_arbiter_pick4.sv
// Round-robin priority encoder: first valid requester at or after ptr.
// Purely combinational, zero latency; no backpressure involvement.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_valid,
  input  req_idx_t         i_ptr,
  output req_idx_t         o_gnt_idx,
  output logic             o_gnt_any
);

  pick_t w_pick;

  assign w_pick    = rr_pick(i_valid, i_ptr);
  assign o_gnt_idx = w_pick.idx;
  assign o_gnt_any = w_pick.found;

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Four-way round-robin arbiter with optional burst lock feeding a one-entry output register.
// Latency 1 cycle input to output, 1 word/cycle sustained; a held output word stalls all grants.
module rr_mux4_arbiter
  import rr_arb_pkg::*;
#(
  parameter int W     = 4,
  parameter int BURST = 1
) (
  input logic               clk,
  input logic               rst_n,
  rr_mux4_arbiter_if.slave  bus
);

  localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

  arb_state_t       r_state;
  req_idx_t         r_ptr;
  req_idx_t         r_lock_id;
  logic [3:0]       r_cnt;
  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  req_idx_t         r_out_src;

  arb_state_t       w_state_nxt;
  req_idx_t         w_ptr_nxt;
  req_idx_t         w_lock_id_nxt;
  logic [3:0]       w_cnt_nxt;
  logic             w_out_valid_nxt;
  logic [W-1:0]     w_out_data_nxt;
  req_idx_t         w_out_src_nxt;

  req_idx_t         w_rr_idx;
  logic             w_any;
  logic             w_load_ok;
  logic             w_lock_hit;
  req_idx_t         w_gnt_idx;
  logic             w_xfer;
  logic [3:0]       w_cnt_eff;
  logic [W-1:0]     w_gnt_dat;
  logic [N_REQ-1:0] w_ready;

  rr_pick4 u_pick (
    .i_valid   (bus.in_valid),
    .i_ptr     (r_ptr),
    .o_gnt_idx (w_rr_idx),
    .o_gnt_any (w_any)
  );

  assign w_load_ok  = !r_out_valid || bus.out_ready;
  assign w_lock_hit = (r_state == ARB_LOCK) && bus.in_valid[r_lock_id];
  assign w_gnt_idx  = w_lock_hit ? r_lock_id : w_rr_idx;
  assign w_xfer     = w_load_ok && w_any;
  // A lock that falls back to round-robin starts the new winner's burst from zero.
  assign w_cnt_eff  = w_lock_hit ? r_cnt : 4'd0;

  always_comb begin
    w_gnt_dat = '0;
    case (w_gnt_idx)
      2'd0:    w_gnt_dat = bus.in_data[0*W +: W];
      2'd1:    w_gnt_dat = bus.in_data[1*W +: W];
      2'd2:    w_gnt_dat = bus.in_data[2*W +: W];
      default: w_gnt_dat = bus.in_data[3*W +: W];
    endcase
  end

  always_comb begin
    w_ready = '0;
    if (rst_n && w_xfer) begin
      w_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_lock_id_nxt   = r_lock_id;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = r_out_valid && !bus.out_ready;
    w_out_data_nxt  = r_out_data;
    w_out_src_nxt   = r_out_src;
    if (w_xfer) begin
      w_out_valid_nxt = 1'b1;
      w_out_data_nxt  = w_gnt_dat;
      w_out_src_nxt   = w_gnt_idx;
      if (w_cnt_eff == BURST_LAST) begin
        w_state_nxt = ARB_FREE;
        w_ptr_nxt   = w_gnt_idx + 2'd1;
        w_cnt_nxt   = 4'd0;
      end else begin
        w_state_nxt   = ARB_LOCK;
        w_lock_id_nxt = w_gnt_idx;
        w_cnt_nxt     = w_cnt_eff + 4'd1;
      end
    end else if (w_load_ok && (r_state == ARB_LOCK)) begin
      // Nobody is requesting, so the locked requester went idle.
      w_state_nxt = ARB_FREE;
      w_ptr_nxt   = r_lock_id + 2'd1;
      w_cnt_nxt   = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB_FREE;
      r_ptr       <= '0;
      r_lock_id   <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_lock_id   <= w_lock_id_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_src   <= w_out_src_nxt;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Random and directed stimulus on two arbiters (BURST=1 and BURST=3) against a per-cycle reference model.
module tb_rr_mux4_arbiter;
  import rr_arb_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_mux4_arbiter_if #(.W(W)) bus0 ();
  rr_mux4_arbiter_if #(.W(W)) bus1 ();

  rr_mux4_arbiter #(.W(W), .BURST(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  rr_mux4_arbiter #(.W(W), .BURST(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [3:0]   vld_drv [2];
  logic [4*W-1:0] dat_drv [2];
  logic         ordy_drv [2];
  logic [3:0]   rdy_o [2];
  logic         ov_o [2];
  logic [W-1:0] od_o [2];
  logic [1:0]   os_o [2];

  assign bus0.in_valid  = vld_drv[0];
  assign bus0.in_data   = dat_drv[0];
  assign bus0.out_ready = ordy_drv[0];
  assign bus1.in_valid  = vld_drv[1];
  assign bus1.in_data   = dat_drv[1];
  assign bus1.out_ready = ordy_drv[1];
  assign rdy_o[0] = bus0.in_ready;
  assign ov_o[0]  = bus0.out_valid;
  assign od_o[0]  = bus0.out_data;
  assign os_o[0]  = bus0.out_src;
  assign rdy_o[1] = bus1.in_ready;
  assign ov_o[1]  = bus1.out_valid;
  assign od_o[1]  = bus1.out_data;
  assign os_o[1]  = bus1.out_src;

  // Requester-side bookkeeping: a pending request holds valid and data until granted.
  bit           pend [2][4];
  logic [W-1:0] pdat [2][4];
  bit           ordy [2];

  int m_ptr [2], m_lid [2], m_cnt [2], m_od [2], m_os [2];
  bit m_lock [2], m_ov [2];
  int burst_len [2] = '{1, 3};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL dut%0d %s: got %0h expected %0h at %0t", d, tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_lid[d] = 0; m_cnt[d] = 0; m_od[d] = 0; m_os[d] = 0;
      m_lock[d] = 0; m_ov[d] = 0;
    end
  endtask

  function automatic int winner(input int d, input logic [3:0] v);
    if (m_lock[d] && v[m_lid[d]]) return m_lid[d];
    for (int k = 0; k < 4; k++) begin
      if (v[(m_ptr[d] + k) % 4]) return (m_ptr[d] + k) % 4;
    end
    return -1;
  endfunction

  task automatic apply();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        vld_drv[d][i] = pend[d][i];
        dat_drv[d][i*W +: W] = pdat[d][i];
      end
      ordy_drv[d] = ordy[d];
    end
  endtask

  task automatic check_and_step();
    int w, ce;
    bit load_ok, xfer;
    logic [3:0] exp_rdy;
    for (int d = 0; d < 2; d++) begin
      w = winner(d, vld_drv[d]);
      load_ok = !m_ov[d] || ordy[d];
      xfer = load_ok && (w >= 0);
      exp_rdy = xfer ? (4'b0001 << w) : 4'b0000;
      chk(d, "in_ready", 32'(rdy_o[d]), 32'(exp_rdy));
      chk(d, "out_valid", 32'(ov_o[d]), 32'(m_ov[d]));
      chk(d, "out_data", 32'(od_o[d]), m_od[d]);
      chk(d, "out_src", 32'(os_o[d]), m_os[d]);
      if (xfer) begin
        ce = (m_lock[d] && w == m_lid[d]) ? m_cnt[d] : 0;
        if (ce + 1 >= burst_len[d]) begin
          m_ptr[d] = (w + 1) % 4; m_lock[d] = 0; m_cnt[d] = 0;
        end else begin
          m_lock[d] = 1; m_lid[d] = w; m_cnt[d] = ce + 1;
        end
        m_ov[d] = 1; m_od[d] = int'(pdat[d][w]); m_os[d] = w;
        pend[d][w] = 0;
      end else begin
        if (m_ov[d] && ordy[d]) m_ov[d] = 0;
        if (load_ok && m_lock[d]) begin
          m_lock[d] = 0; m_cnt[d] = 0; m_ptr[d] = (m_lid[d] + 1) % 4;
        end
      end
    end
  endtask

  task automatic cycle(input int req_pct, input int rdy_pct, input bit fixed_dat);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[d][i] && $urandom_range(0, 99) < req_pct) begin
          pend[d][i] = 1;
          pdat[d][i] = fixed_dat ? W'(10 + i) : W'($urandom_range(0, 15));
        end
      end
      ordy[d] = $urandom_range(0, 99) < rdy_pct;
    end
    apply();
    @(negedge clk);
    check_and_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs(input bit v);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        pend[d][i] = v;
        pdat[d][i] = W'(10 + i);
      end
      ordy[d] = 1;
    end
    apply();
  endtask

  initial begin
    model_reset();
    clear_reqs(0);
    rst_n = 1'b0;
    #2;
    clear_reqs(1);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_in_ready", 32'(rdy_o[d]), 32'd0);
      chk(d, "rst_out_valid", 32'(ov_o[d]), 32'd0);
      chk(d, "rst_out_data", 32'(od_o[d]), 32'd0);
      chk(d, "rst_out_src", 32'(os_o[d]), 32'd0);
    end
    clear_reqs(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    repeat (5) cycle(0, 100, 0);

    for (int d = 0; d < 2; d++) begin
      pend[d][2] = 1;
      pdat[d][2] = W'(12);
    end
    repeat (3) cycle(0, 100, 0);

    repeat (12) cycle(100, 100, 1);
    repeat (3) cycle(100, 0, 1);
    repeat (6) cycle(100, 100, 1);

    repeat (150) cycle(50, 70, 0);
    repeat (100) cycle(90, 30, 0);
    repeat (100) cycle(20, 90, 0);
    repeat (4) cycle(100, 100, 1);

    // Asynchronous reset landing between clock edges with a word held.
    #3;
    for (int d = 0; d < 2; d++) chk(d, "pre_rst_valid", 32'(ov_o[d]), 32'(m_ov[d]));
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "midrst_out_valid", 32'(ov_o[d]), 32'd0);
      chk(d, "midrst_in_ready", 32'(rdy_o[d]), 32'd0);
    end
    model_reset();
    clear_reqs(0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_reqs(1);
    repeat (10) cycle(100, 100, 1);
    repeat (150) cycle(60, 60, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
